// File: rtl/mem_test_master.sv
// March-style self test for an 8x8 memory: write/read a seeded pattern, then its complement.
// Mismatches are counted (saturating at 15), and the first failing address is latched.
module mem_test_master #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       we,
  output logic       re,
  output logic [2:0] addr,
  output logic [7:0] din,
  input  logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_addr
);

  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] a, a_nxt;
  logic       accept;
  logic       mismatch;

  function automatic logic [7:0] pat0(input logic [2:0] idx);
    return SEED ^ {idx, 2'b00, idx};
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= 3'd0;
      err_count <= 4'd0;
      fail_addr <= 3'd0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      if (accept) begin
        err_count <= 4'd0;
        fail_addr <= 3'd0;
      end else if (mismatch) begin
        err_count <= sat_inc(err_count);
        // Count never returns to zero within a run, so zero marks the first miss.
        if (err_count == 4'd0) fail_addr <= a;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    accept    = 1'b0;
    mismatch  = 1'b0;
    we        = 1'b0;
    re        = 1'b0;
    addr      = 3'd0;
    din       = 8'd0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = W0;
          a_nxt     = 3'd0;
        end
      end
      W0: begin
        we    = 1'b1;
        addr  = a;
        din   = pat0(a);
        a_nxt = a + 3'd1;
        if (a == 3'd7) state_nxt = R0;
      end
      R0: begin
        re       = 1'b1;
        addr     = a;
        mismatch = (dout != pat0(a));
        a_nxt    = a + 3'd1;
        if (a == 3'd7) state_nxt = W1;
      end
      W1: begin
        we    = 1'b1;
        addr  = a;
        din   = ~pat0(a);
        a_nxt = a + 3'd1;
        if (a == 3'd7) state_nxt = R1;
      end
      R1: begin
        re       = 1'b1;
        addr     = a;
        mismatch = (dout != ~pat0(a));
        a_nxt    = a + 3'd1;
        if (a == 3'd7) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == W0) || (state == R0) || (state == W1) || (state == R1);
  assign done = (state == DONE);
  assign pass = done && (err_count == 4'd0);

endmodule
